riscv_pr_ctrl: RTL and testbench
================================

# riscv_pr_ctrl

Per-core sequencer that drives the interrupt, core-reset and partial-reconfiguration controls of one RISC-V block. It sits between the scheduler's command channel and a single RISC-V block wrapper. It executes four operations:
- poke
- evict (quiesce and park)
- resume
- reload (quiesce, reconfigure, restart)

While the core is parked or being reconfigured, it asserts a descriptor-block signal so no new work is dispatched to the core.

## Interface
Parameters:
- SLOT_COUNT, 8, width of active_slots.
- TIMEOUT, 4096, cycles allowed for an interrupt ack or a slot drain.
- RST_CYCLES, 16, cycles core_rst is held after reset entry or after pr_done.
- TMR_WIDTH, $clog2(TIMEOUT+RST_CYCLES+1), internal counter width.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  operation code: 0 poke, 1 evict, 2 resume, 3 reload.
- cmd_ready  out  1  command accept; high only in IDLE.
- done_valid  out  1  one-cycle completion pulse.
- done_status  out  1  0 ok, 1 timeout; valid only with done_valid.
- poke_int  out  1  level interrupt request to the core.
- poke_int_ack  in  1  core acknowledge, sampled as a level.
- evict_int  out  1  level interrupt request to the core.
- evict_int_ack  in  1  core acknowledge, sampled as a level.
- active_slots  in  SLOT_COUNT  per-slot busy bits from the core.
- desc_block  out  1  scheduler must not issue in_desc to this core.
- core_rst  out  1  core reset to the RISC-V block.
- pr_start  out  1  one-cycle request to the PR loader.
- pr_done  in  1  PR loader finished; single-cycle pulse.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, POKE, EVICT, DRAIN, RST_HOLD, PR_WAIT, PR_HOLD, DONE.
- IDLE: cmd_ready=1. A command is accepted on cmd_valid&&cmd_ready; op is latched and the timer is cleared. Next state:
  - op0 -> POKE
  - op1 or op3 -> EVICT
  - op2 -> RST_HOLD
- POKE: poke_int=1. poke_int_ack=1 -> DONE with status 0. Timer reaching TIMEOUT-1 -> DONE with status 1.
- EVICT: desc_block=1, evict_int=1. evict_int_ack=1 -> DRAIN with timer cleared. Timeout -> DONE with status 1 and desc_block cleared.
- DRAIN: desc_block=1, waits for active_slots==0. On drain:
  - op1 -> DONE with status 0; desc_block stays 1 (core parked).
  - op3 -> RST_HOLD
  - Timeout -> DONE with status 1 and desc_block cleared.
- RST_HOLD: core_rst=1 for exactly RST_CYCLES cycles.
  - op2 -> DONE with status 0; desc_block cleared when entering DONE.
  - op3 -> PR_WAIT, with pr_start pulsed on the first PR_WAIT cycle.
- PR_WAIT: core_rst=1, desc_block=1. No timeout. pr_done -> PR_HOLD with timer cleared.
- PR_HOLD: core_rst=1 for RST_CYCLES cycles, then DONE with status 0 and desc_block cleared.
- DONE: done_valid=1 for one cycle, then IDLE.
- Ack inputs are ignored outside their own phase. pr_done is ignored outside PR_WAIT.
- Ack and timeout in the same cycle: the ack wins and status is 0.
- Poke while parked is legal; desc_block is unchanged.
- Resume when not parked is legal: it still pulses core_rst and leaves desc_block at 0.

## Timing
- All outputs except cmd_ready and busy are registered. cmd_ready and busy are decoded from the state register.
- Reset values: cmd_ready=1, busy=0; all other outputs 0; state IDLE.
- Asserting rst_n mid-operation returns to IDLE immediately, with no done pulse.
- Command accepted at cycle T: the phase output (poke_int, evict_int or core_rst) is high from T+1.
- Ack first high at cycle A: the interrupt is low at A+1, done_valid or the next phase starts at A+1, and cmd_ready is high at A+2 if the next state is DONE.
- Timeout: the interrupt drops and done_valid rises exactly TIMEOUT cycles after phase entry.
- core_rst high-time:
  - resume: exactly RST_CYCLES cycles.
  - reload: covers RST_HOLD, PR_WAIT and PR_HOLD contiguously, with no glitch between states.
- pr_start is high exactly one cycle, on the first cycle of PR_WAIT.
- DRAIN with active_slots already 0 on entry takes one cycle.

## Test plan
- Poke: op0 accepted at T, ack held high at T+5 -> poke_int high T+1..T+5, done_valid=1 and status=0 at T+6, cmd_ready=1 at T+7.
- Evict: op1, ack at T+3, active_slots=8'h05 clearing to 0 at T+10 -> desc_block rises at T+1 and stays 1 after done; done_valid at T+11.
- Timeout: TIMEOUT=16, op1, ack never asserted -> evict_int drops and done_valid=1 with status=1 at T+17; desc_block=0.
- Reload: op3, immediate ack, slots idle, RST_CYCLES=4, pr_done 20 cycles after pr_start -> single pr_start pulse; core_rst continuous until 4 cycles after pr_done; desc_block=0 after done.
- Resume after park: op1 then op2 -> core_rst high exactly 4 cycles; desc_block falls at the DONE cycle.
- Reset mid-reload: drop rst_n during PR_WAIT -> all outputs return to reset values asynchronously with no done_valid; an op0 afterwards is accepted normally.

Source files
------------

// File: rtl/riscv_pr_ctrl.sv
// Per-core sequencer for interrupt, core reset and partial reconfiguration
// of one RISC-V block, driven by a scheduler command channel.
module riscv_pr_ctrl #(
  parameter int SLOT_COUNT = 8,
  parameter int TIMEOUT    = 4096,
  parameter int RST_CYCLES = 16,
  parameter int TMR_WIDTH  = $clog2(TIMEOUT + RST_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  output logic                  done_valid,
  output logic                  done_status,
  output logic                  poke_int,
  input  logic                  poke_int_ack,
  output logic                  evict_int,
  input  logic                  evict_int_ack,
  input  logic [SLOT_COUNT-1:0] active_slots,
  output logic                  desc_block,
  output logic                  core_rst,
  output logic                  pr_start,
  input  logic                  pr_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POKE,
    S_EVICT,
    S_DRAIN,
    S_RST_HOLD,
    S_PR_WAIT,
    S_PR_HOLD,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_POKE   = 2'd0;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_RELOAD = 2'd3;

  localparam logic [TMR_WIDTH-1:0] TO_LAST  = TMR_WIDTH'(TIMEOUT - 1);
  localparam logic [TMR_WIDTH-1:0] RST_LAST = TMR_WIDTH'(RST_CYCLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [1:0]           op_q;
  logic [1:0]           op_d;
  logic [TMR_WIDTH-1:0] tmr_q;
  logic                 status_d;
  logic                 desc_d;
  logic                 to_hit;
  logic                 rst_hit;
  logic                 drained;
  logic                 in_rst;

  assign to_hit    = (tmr_q == TO_LAST);
  assign rst_hit   = (tmr_q == RST_LAST);
  assign drained   = (active_slots == '0);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    status_d = done_status;
    desc_d   = desc_block;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          case (cmd_op)
            OP_POKE:   state_d = S_POKE;
            OP_RESUME: state_d = S_RST_HOLD;
            default: begin
              state_d = S_EVICT;
              desc_d  = 1'b1;
            end
          endcase
        end
      end
      S_POKE: begin
        if (poke_int_ack) begin
          state_d  = S_DONE;
          status_d = 1'b0;
        end else if (to_hit) begin
          state_d  = S_DONE;
          status_d = 1'b1;
        end
      end
      S_EVICT: begin
        if (evict_int_ack) begin
          state_d = S_DRAIN;
        end else if (to_hit) begin
          state_d  = S_DONE;
          status_d = 1'b1;
          desc_d   = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          if (op_q == OP_RELOAD) begin
            state_d = S_RST_HOLD;
          end else begin
            // core stays parked: desc_block is left asserted
            state_d  = S_DONE;
            status_d = 1'b0;
          end
        end else if (to_hit) begin
          state_d  = S_DONE;
          status_d = 1'b1;
          desc_d   = 1'b0;
        end
      end
      S_RST_HOLD: begin
        if (rst_hit) begin
          if (op_q == OP_RELOAD) begin
            state_d = S_PR_WAIT;
          end else begin
            state_d  = S_DONE;
            status_d = 1'b0;
            desc_d   = 1'b0;
          end
        end
      end
      S_PR_WAIT: begin
        if (pr_done) state_d = S_PR_HOLD;
      end
      S_PR_HOLD: begin
        if (rst_hit) begin
          state_d  = S_DONE;
          status_d = 1'b0;
          desc_d   = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  assign in_rst = (state_d == S_RST_HOLD) ||
                  (state_d == S_PR_WAIT) ||
                  (state_d == S_PR_HOLD);

  // outputs registered from the next state so they track state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'd0;
      tmr_q       <= '0;
      done_valid  <= 1'b0;
      done_status <= 1'b0;
      poke_int    <= 1'b0;
      evict_int   <= 1'b0;
      desc_block  <= 1'b0;
      core_rst    <= 1'b0;
      pr_start    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tmr_q       <= (state_d != state_q) ? '0 : tmr_q + TMR_WIDTH'(1);
      done_valid  <= (state_d == S_DONE);
      done_status <= status_d;
      poke_int    <= (state_d == S_POKE);
      evict_int   <= (state_d == S_EVICT);
      desc_block  <= desc_d;
      core_rst    <= in_rst;
      pr_start    <= (state_d == S_PR_WAIT) && (state_q != S_PR_WAIT);
    end
  end

endmodule

// File: tb/tb_riscv_pr_ctrl.sv
// Randomized scoreboard bench for riscv_pr_ctrl.
// Expected completions come from a cycle-count model of each operation.
module tb_riscv_pr_ctrl;

  localparam int SC = 8;
  localparam int TO = 16;
  localparam int R  = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          done_valid;
  logic          done_status;
  logic          poke_int;
  logic          poke_int_ack;
  logic          evict_int;
  logic          evict_int_ack;
  logic [SC-1:0] active_slots;
  logic          desc_block;
  logic          core_rst;
  logic          pr_start;
  logic          pr_done;
  logic          busy;

  riscv_pr_ctrl #(
    .SLOT_COUNT(SC),
    .TIMEOUT(TO),
    .RST_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(cmd_ready),
    .done_valid(done_valid),
    .done_status(done_status),
    .poke_int(poke_int),
    .poke_int_ack(poke_int_ack),
    .evict_int(evict_int),
    .evict_int_ack(evict_int_ack),
    .active_slots(active_slots),
    .desc_block(desc_block),
    .core_rst(core_rst),
    .pr_start(pr_start),
    .pr_done(pr_done),
    .busy(busy)
  );

  typedef struct {
    int done_cyc;
    int prs;
    int st;
    int desc;
    int rstc;
    int pokec;
    int evc;
    int lowc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   parked = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int out_vec();
    return int'({cmd_ready, busy, done_valid, done_status, poke_int,
                 evict_int, desc_block, core_rst, pr_start});
  endfunction

  task automatic idle_inputs();
    cmd_valid     = 1'b0;
    cmd_op        = 2'd0;
    poke_int_ack  = 1'b0;
    evict_int_ack = 1'b0;
    active_slots  = '0;
    pr_done       = 1'b0;
  endtask

  task automatic recover();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    q.delete();
    parked = 0;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  // Monitor: accumulates per-operation output activity, checks on done.
  initial begin
    int   n_rst, n_rise, n_poke, n_ev, n_low, n_prs;
    bit   rst_prev;
    exp_t e;
    n_rst = 0; n_rise = 0; n_poke = 0; n_ev = 0; n_low = 0; n_prs = 0;
    rst_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_rst = 0; n_rise = 0; n_poke = 0; n_ev = 0; n_low = 0; n_prs = 0;
        rst_prev = 0;
      end else begin
        n_rst += int'(core_rst);
        if (core_rst && !rst_prev) n_rise++;
        rst_prev = core_rst;
        n_poke += int'(poke_int);
        n_ev += int'(evict_int);
        if (busy && !done_valid && !desc_block) n_low++;
        if (pr_start) begin
          n_prs++;
          chk("pr_start_sb", int'(q.size() > 0), 1);
          if (q.size() > 0) chk("pr_start_cyc", cyc, q[0].prs);
        end
        if (done_valid) begin
          chk("done_sb", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("done_cyc", cyc, e.done_cyc);
            chk("done_status", int'(done_status), e.st);
            chk("desc_at_done", int'(desc_block), e.desc);
            chk("core_rst_cycles", n_rst, e.rstc);
            chk("core_rst_rises", n_rise, (e.rstc > 0) ? 1 : 0);
            chk("pr_start_pulses", n_prs, (e.prs >= 0) ? 1 : 0);
            chk("poke_int_cycles", n_poke, e.pokec);
            chk("evict_int_cycles", n_ev, e.evc);
            chk("desc_low_cycles", n_low, e.lowc);
          end
          n_rst = 0; n_rise = 0; n_poke = 0; n_ev = 0; n_low = 0; n_prs = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("idle_wait", int'(cmd_ready === 1'b1), 1);
    if (cmd_ready !== 1'b1) recover();
  endtask

  // a: cycle after accept when the ack goes high; k: drain cycles before
  // slots clear; p: cycles from pr_start to pr_done.
  task automatic run_txn(input int op, input int a, input int k, input int p);
    exp_t e;
    int   t0, lat, prs;
    bit   was_parked;
    wait_idle();
    t0 = cyc;
    was_parked = parked;
    prs = -1;
    lat = 0;
    e = '{done_cyc: 0, prs: -1, st: 0, desc: 0, rstc: 0,
          pokec: 0, evc: 0, lowc: 0};
    case (op)
      0: begin
        lat = (a <= TO) ? a + 1 : TO + 1;
        e.st = (a <= TO) ? 0 : 1;
        e.pokec = (a <= TO) ? a : TO;
        e.desc = int'(parked);
      end
      2: begin
        lat = R + 1;
        e.rstc = R;
        parked = 0;
      end
      default: begin
        e.evc = (a <= TO) ? a : TO;
        if (a > TO) begin
          lat = TO + 1;
          e.st = 1;
          parked = 0;
        end else if (k >= TO) begin
          lat = a + 1 + TO;
          e.st = 1;
          parked = 0;
        end else if (op == 1) begin
          lat = a + k + 2;
          e.desc = 1;
          parked = 1;
        end else begin
          prs = a + k + 2 + R;
          lat = prs + p + 1 + R;
          e.rstc = 2 * R + p + 1;
          parked = 0;
        end
      end
    endcase
    e.done_cyc = t0 + lat;
    e.prs = (prs < 0) ? -1 : t0 + prs;
    e.lowc = (op == 1 || op == 3 || was_parked) ? 0 : lat - 1;
    q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op = op[1:0];
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      poke_int_ack = (op == 0) ? (c >= a) : ($urandom_range(0, 3) == 0);
      evict_int_ack = (op == 1 || op == 3) ? (c >= a)
                                           : ($urandom_range(0, 3) == 0);
      if ((op == 1 || op == 3) && c < a + 1 + k)
        active_slots = SC'($urandom_range(1, 255));
      else if (op == 1 || op == 3)
        active_slots = '0;
      else
        active_slots = SC'($urandom_range(0, 255));
      if (op == 3)
        pr_done = (prs >= 0) && (c == prs + p);
      else
        pr_done = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic reset_mid_reload();
    exp_t e;
    int   t0, w;
    wait_idle();
    t0 = cyc;
    e = '{done_cyc: -1, prs: t0 + 3 + R, st: 0, desc: 0, rstc: 0,
          pokec: 0, evc: 0, lowc: 0};
    q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    evict_int_ack = 1'b1;
    active_slots = '0;
    w = 0;
    while (pr_start !== 1'b1 && w < 60) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("reach_pr_wait", int'(pr_start === 1'b1), 1);
    repeat (2) @(posedge clk);
    #3;
    chk("pr_wait_core_rst", int'(core_rst), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), 9'b1_0000_0000);
    q.delete();
    parked = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset_outputs", out_vec(), 9'b1_0000_0000);
    rst_n = 1'b1;
  endtask

  initial begin
    int op, a, k, p;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), 9'b1_0000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(0, 5, 0, 0);
    run_txn(1, 3, 6, 0);
    run_txn(0, 2, 0, 0);
    run_txn(2, 1, 0, 0);
    run_txn(2, 1, 0, 0);
    run_txn(1, TO + 5, 0, 0);
    run_txn(0, TO + 5, 0, 0);
    run_txn(0, TO, 0, 0);
    run_txn(1, TO, TO - 1, 0);
    run_txn(1, 1, TO, 0);
    run_txn(3, 1, 0, 20);
    run_txn(3, 2, 3, 0);
    run_txn(3, TO + 2, 0, 5);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      a = ($urandom_range(0, 5) == 0) ? TO + 3 : $urandom_range(1, TO);
      k = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, TO - 1);
      p = $urandom_range(0, 24);
      run_txn(op, a, k, p);
    end
    reset_mid_reload();
    @(posedge clk);
    #1;
    run_txn(0, 3, 0, 0);
    run_txn(1, 2, 2, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
